// File: rtl/mux_n_pipe_reg_if.sv
// Bus bundle for mux_n_pipe_reg: select inputs, pipeline controls and registered results.
// SEL_W is derived from NUM_IN so that the select width always matches the input count.
interface mux_n_pipe_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        data_comb;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    sel_err;
    logic [7:0]              err_cnt;

    modport master (
        output data_in, sel, in_valid, stall, flush,
        input  data_comb, data_out, out_valid, sel_err, err_cnt
    );

    modport slave (
        input  data_in, sel, in_valid, stall, flush,
        output data_comb, data_out, out_valid, sel_err, err_cnt
    );
endinterface

// File: rtl/mux_n_pipe_reg.sv
// N:1 select with a stall/flush-aware pipeline register for the MIPS32 pipeline boundaries.
// Optional MUX_SEL_ERR_CNT_EN builds a saturating counter of out-of-range selects.
module mux_n_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input logic              clk,
    input logic              reset,
    mux_n_pipe_reg_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [WIDTH-1:0] sel_data;
    logic             in_range;
    logic             load;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             err_q;

    // Explicit compare per input keeps out-of-range selects at zero instead of X.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_data = bus.data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // One extra bit so NUM_IN is representable; folds to constant true for power-of-two NUM_IN.
    assign in_range = ({1'b0, bus.sel} < (SEL_W+1)'(NUM_IN));
    assign load     = !bus.flush && !bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.flush) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                data_q  <= sel_data;
                valid_q <= 1'b1;
                err_q   <= !in_range;
            end else begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (load && bus.in_valid && !in_range && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.data_comb = sel_data;
    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_mux_n_pipe_reg.sv
// Self-checking bench for mux_n_pipe_reg: a NUM_IN=4 and a NUM_IN=5 instance against a behavioural model.
// Expected err_cnt depends on whether MUX_SEL_ERR_CNT_EN is defined for the build.
module tb_mux_n_pipe_reg;
`ifdef MUX_SEL_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mux_n_pipe_reg_if #(.WIDTH(32), .NUM_IN(4)) b4 ();
    mux_n_pipe_reg_if #(.WIDTH(32), .NUM_IN(5)) b5 ();

    mux_n_pipe_reg #(.WIDTH(32), .NUM_IN(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    mux_n_pipe_reg #(.WIDTH(32), .NUM_IN(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

    // Model state, index 0 = NUM_IN 4 instance, index 1 = NUM_IN 5 instance.
    logic [31:0] m_out   [2];
    logic        m_valid [2];
    logic        m_err   [2];
    logic [7:0]  m_cnt   [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired before end of test");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_comb4();
        int s = int'(b4.sel);
        return (s < 4) ? b4.data_in[s*32 +: 32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_comb5();
        int s = int'(b5.sel);
        return (s < 5) ? b5.data_in[s*32 +: 32] : 32'h0;
    endfunction

    task automatic model_step(input int k, input int n, input int s, input bit v,
                              input bit st, input bit fl, input logic [31:0] w);
        if (reset) begin
            m_out[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end else if (fl) begin
            m_out[k] = 0; m_valid[k] = 0; m_err[k] = 0;
        end else if (!st) begin
            m_valid[k] = v;
            m_err[k]   = v && (s >= n);
            if (v) m_out[k] = w;
            if (CNT_EN && v && (s >= n) && m_cnt[k] < 8'd255) m_cnt[k] = m_cnt[k] + 8'd1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 4, int'(b4.sel), b4.in_valid, b4.stall, b4.flush, exp_comb4());
        model_step(1, 5, int'(b5.sel), b5.in_valid, b5.stall, b5.flush, exp_comb5());
    end

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) b4.data_in[i*32 +: 32] = $urandom;
        for (int i = 0; i < 5; i++) b5.data_in[i*32 +: 32] = $urandom;
        b4.sel      = 2'($urandom_range(0, 3));
        b5.sel      = 3'($urandom_range(0, 7));
        b4.in_valid = 1'($urandom_range(0, 1));
        b5.in_valid = 1'($urandom_range(0, 1));
        b4.stall    = ($urandom_range(0, 3) == 0);
        b5.stall    = ($urandom_range(0, 3) == 0);
        b4.flush    = ($urandom_range(0, 7) == 0);
        b5.flush    = ($urandom_range(0, 7) == 0);
    endtask

    task automatic idle5();
        b5.in_valid = 0; b5.stall = 0; b5.flush = 0; b5.sel = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rand_inputs();
            @(posedge clk); #1;
            n_checks++;
            if ({b4.data_out, b4.out_valid, b4.sel_err, b4.err_cnt} !== 42'h0) begin
                n_fail++;
                $display("FAIL reset4 got %h exp 0", {b4.data_out, b4.out_valid, b4.sel_err, b4.err_cnt});
            end
            n_checks++;
            if ({b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt} !== 42'h0) begin
                n_fail++;
                $display("FAIL reset5 got %h exp 0", {b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt});
            end
        end
        @(negedge clk);
        reset = 0;
        b4.in_valid = 0; b4.stall = 0; b4.flush = 0;
        idle5();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) b4.data_in[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        b4.in_valid = 1; b4.stall = 0; b4.flush = 0;
        for (int s = 0; s < 4; s++) begin
            if (s != 0) @(negedge clk);
            b4.sel = 2'(s);
            #1;
            n_checks++;
            if (b4.data_comb !== 32'hA000_0000 + 32'(s)) begin
                n_fail++;
                $display("FAIL sweep_comb sel=%0d got %h exp %h", s, b4.data_comb, 32'hA000_0000 + 32'(s));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({b4.data_out, b4.out_valid} !== {32'hA000_0000 + 32'(s), 1'b1}) begin
                n_fail++;
                $display("FAIL sweep_reg sel=%0d got %h/%b exp %h/1", s, b4.data_out, b4.out_valid,
                         32'hA000_0000 + 32'(s));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        @(negedge clk);
        b4.sel = 2; b4.in_valid = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({b4.data_out, b4.out_valid} !== {32'hA000_0002, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_load got %h/%b exp a0000002/1", b4.data_out, b4.out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            b4.stall = 1;
            b4.sel = 2'($urandom_range(0, 3));
            b4.in_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) b4.data_in[i*32 +: 32] = $urandom;
            @(posedge clk); #1;
            n_checks++;
            if ({b4.data_out, b4.out_valid} !== {32'hA000_0002, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d got %h/%b exp a0000002/1", c, b4.data_out, b4.out_valid);
            end
        end
        @(negedge clk);
        b4.stall = 0; b4.in_valid = 1; b4.sel = 1;
        w = $urandom;
        b4.data_in[32 +: 32] = w;
        @(posedge clk); #1;
        n_checks++;
        if ({b4.data_out, b4.out_valid} !== {w, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_release got %h/%b exp %h/1", b4.data_out, b4.out_valid, w);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        b4.stall = 1; b4.flush = 1; b4.in_valid = 1; b4.sel = 3;
        @(posedge clk); #1;
        n_checks++;
        if ({b4.data_out, b4.out_valid, b4.sel_err} !== 34'h0) begin
            n_fail++;
            $display("FAIL flush_over_stall got %h/%b/%b exp 0/0/0", b4.data_out, b4.out_valid, b4.sel_err);
        end
        @(negedge clk);
        b4.stall = 0; b4.flush = 0; b4.in_valid = 0; b4.sel = 2;
        @(posedge clk); #1;
        n_checks++;
        if ({b4.data_out, b4.out_valid} !== 33'h0) begin
            n_fail++;
            $display("FAIL bubble got %h/%b exp 0/0", b4.data_out, b4.out_valid);
        end
    endtask

    task automatic test_sel_range();
        @(negedge clk);
        b4.in_valid = 0;
        for (int i = 0; i < 5; i++) b5.data_in[i*32 +: 32] = $urandom | 32'h1;
        b5.sel = 6; b5.in_valid = 1; b5.stall = 0; b5.flush = 0;
        #1;
        n_checks++;
        if (b5.data_comb !== 32'h0) begin
            n_fail++;
            $display("FAIL range_comb got %h exp 0", b5.data_comb);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt} !== {32'h0, 1'b1, 1'b1, CNT_EN ? 8'd1 : 8'd0}) begin
            n_fail++;
            $display("FAIL range_first got %h/%b/%b/%h", b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt);
        end
        repeat (299) @(posedge clk);
        #1;
        n_checks++;
        if ({b5.sel_err, b5.err_cnt} !== {1'b1, CNT_EN ? 8'hFF : 8'h00}) begin
            n_fail++;
            $display("FAIL range_saturate got %b/%h exp 1/%h", b5.sel_err, b5.err_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
        @(negedge clk);
        idle5();
    endtask

    task automatic test_reset_during_stall();
        logic [31:0] w;
        reset = 1;
        @(negedge clk);
        reset = 0;
        b5.sel = 7; b5.in_valid = 1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (b5.err_cnt !== (CNT_EN ? 8'd5 : 8'd0)) begin
            n_fail++;
            $display("FAIL pre_cnt got %h exp %h", b5.err_cnt, CNT_EN ? 8'd5 : 8'd0);
        end
        @(negedge clk);
        b5.stall = 1; b5.sel = 2;
        @(negedge clk);
        reset = 1; b5.sel = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt} !== 42'h0) begin
            n_fail++;
            $display("FAIL reset_in_stall got %h exp 0", {b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt});
        end
        @(negedge clk);
        reset = 0; b5.stall = 0; b5.sel = 1; b5.in_valid = 1;
        w = $urandom;
        b5.data_in[32 +: 32] = w;
        @(posedge clk); #1;
        n_checks++;
        if ({b5.data_out, b5.out_valid, b5.sel_err} !== {w, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_load got %h/%b/%b exp %h/1/0", b5.data_out, b5.out_valid, b5.sel_err, w);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rand_inputs();
            reset = ($urandom_range(0, 49) == 0);
            #1;
            n_checks++;
            if (b4.data_comb !== exp_comb4()) begin
                n_fail++;
                $display("FAIL rnd_comb4 c=%0d got %h exp %h", c, b4.data_comb, exp_comb4());
            end
            n_checks++;
            if (b5.data_comb !== exp_comb5()) begin
                n_fail++;
                $display("FAIL rnd_comb5 c=%0d got %h exp %h", c, b5.data_comb, exp_comb5());
            end
            @(posedge clk); #1;
            n_checks++;
            if ({b4.data_out, b4.out_valid, b4.sel_err, b4.err_cnt} !== {m_out[0], m_valid[0], m_err[0], m_cnt[0]}) begin
                n_fail++;
                $display("FAIL rnd_regs4 c=%0d got %h exp %h", c, {b4.data_out, b4.out_valid, b4.sel_err, b4.err_cnt},
                         {m_out[0], m_valid[0], m_err[0], m_cnt[0]});
            end
            n_checks++;
            if ({b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt} !== {m_out[1], m_valid[1], m_err[1], m_cnt[1]}) begin
                n_fail++;
                $display("FAIL rnd_regs5 c=%0d got %h exp %h", c, {b5.data_out, b5.out_valid, b5.sel_err, b5.err_cnt},
                         {m_out[1], m_valid[1], m_err[1], m_cnt[1]});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1;
        rand_inputs();
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_sel_range();
        test_reset_during_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
